// File: rtl/aes_lite_pkg.sv
// Shared constants and types for the AES-lite result path.
package aes_lite_pkg;
    localparam int DATA_W        = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CW    = 8;

    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/aes_lite_fifo.sv
// First-word fall-through byte FIFO; the head is read straight from registered storage.
module aes_lite_fifo
    import aes_lite_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  data_t            data_in,
    output data_t            out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    data_t            mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] wr_en;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage is never reset; only pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem[i] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr_reg];
endmodule

// File: rtl/aes_lite_result_buf.sv
// Captures one byte per rising edge of core_ready into a small FIFO and tracks
// accepted captures plus a sticky overflow flag for bytes dropped while full.
module aes_lite_result_buf
    import aes_lite_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = DEFAULT_CW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     core_ready,
    input  logic [DATA_W-1:0]        core_result,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [CW-1:0]            captures
);
    logic          ready_q;
    logic          overflow_reg;
    logic [CW-1:0] captures_reg;
    logic          cap_event;
    logic          push_req;
    logic          pop;
    logic          push;
    logic          drop;

    // ready_q resets high so a done flag already asserted at release is not a new result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= core_ready;
        end
    end

    assign cap_event = core_ready && !ready_q;
    assign push_req  = cap_event && !clear;
    assign pop       = out_valid && out_ready && !clear;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            overflow_reg <= 1'b0;
            captures_reg <= '0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (push) begin
                captures_reg <= captures_reg + CW'(1);
            end
        end
    end

    aes_lite_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .data_in   (core_result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign overflow = overflow_reg;
    assign captures = captures_reg;
endmodule

// File: doc/aes_lite_result_buf.md
AES_LITE_RESULT_BUF -- requirements
Module: aes_lite_result_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter CW, default 8, width of the capture counter.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port core_ready, input, 1 bit: level-high done flag from the upstream AES-lite core.
REQ-006 SHALL have port core_result, input, 8 bits: ciphertext byte, valid while core_ready is high.
REQ-007 SHALL have port clear, input, 1 bit: synchronous flush request.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts a byte.
REQ-009 SHALL have port out_valid, output, 1 bit: FIFO head is valid.
REQ-010 SHALL have port out_data, output, 8 bits: FIFO head byte.
REQ-011 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have ports full and empty, output, 1 bit each: occupancy flags.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag for a dropped capture.
REQ-014 SHALL have port captures, output, CW bits: count of accepted captures, wrapping.

Function
REQ-015 SHALL register core_ready into ready_q every cycle; capture event = core_ready && !ready_q.
REQ-016 SHALL sample core_result in the capture-event cycle; a level held high yields exactly one capture.
REQ-017 SHALL push the captured byte on the same edge; out_valid rises the cycle after the event edge (latency 1).
REQ-018 SHALL be first-word fall-through: out_data = oldest entry and out_valid = !empty, both registered-state derived with no combinational path from inputs.
REQ-019 SHALL pop on the edge where out_valid && out_ready; out_data SHALL not change while out_valid && !out_ready.
REQ-020 SHALL ignore out_ready when empty; count SHALL never underflow.
REQ-021 SHALL, on push while full without a pop, drop the byte, leave FIFO contents unchanged, set overflow, and not increment captures.
REQ-022 SHALL, on push and pop in the same cycle when full, accept both; count is unchanged and overflow is not set.
REQ-023 SHALL, on push and pop in the same cycle when not empty and not full, keep count unchanged and preserve order.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
REQ-025 SHALL increment captures by 1 per accepted push, wrapping from 2^CW-1 to 0.
REQ-026 SHALL, on clear, empty the FIFO and zero overflow and captures on that edge; a capture event in the same cycle is discarded; ready_q still updates.
REQ-027 SHALL have clear take priority over push and pop; rst_n takes priority over clear.

Reset
REQ-028 SHALL, with rst_n low at an edge, set count 0, pointers 0, empty 1, full 0, out_valid 0, overflow 0, and captures 0.
REQ-029 SHALL reset ready_q to 1, so a core_ready already high on reset release is not captured.
REQ-030 SHALL, on reset asserted mid-operation, discard buffered bytes; FIFO storage need not be reset.
REQ-031 SHALL drive out_data 0x00 while empty.

Structure
REQ-032 SHALL take DEPTH and CW defaults and the byte width constant (8) from shared package aes_lite_pkg.
REQ-033 SHALL place storage, pointers and count in sub-module aes_lite_fifo; the top holds edge detect, overflow and captures.

Verification
REQ-034 Reset release with core_ready=1, core_result=0x3C -> no capture; empty=1, captures=0.
REQ-035 Drive 0 then 1 with result 0xA7, hold for 10 cycles, out_ready=0 -> exactly one entry; out_data=0xA7 one cycle after the edge; count=1.
REQ-036 Five pulses 0x11,0x22,0x33,0x44,0x55 with DEPTH=4 and out_ready=0 -> full=1, overflow=1, captures=4; drain yields 0x11..0x44 in order.
REQ-037 Full FIFO, out_ready=1 and a capture of 0x99 in the same cycle -> count stays 4, overflow=0, 0x99 emerges last.
REQ-038 Three entries buffered, then clear pulsed together with a capture -> next cycle empty=1, count=0, overflow=0, captures=0.
REQ-039 Random core_ready pulses with random out_ready stalls for 2000 cycles -> scoreboard order matches, and captures mod 256 equals the accepted push count.
